// File: rtl/mux9_rr_arbiter_pkg.sv
// mux9_arb_pkg: shared constants, FSM encoding and pick helper for the 9-way round-robin arbiter
package mux9_arb_pkg;
  localparam int N_REQ = 9;
  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] LAST_RST = 4'd8;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  function automatic logic [SEL_W-1:0] mod9_add(input logic [SEL_W-1:0] a, input logic [SEL_W-1:0] b);
    logic [SEL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 5'd9) s = s - 5'd9;
    return s[SEL_W-1:0];
  endfunction
endpackage

// File: rtl/mux9_rr_arbiter_if.sv
// mux9_rr_arbiter_if: request/select/grant bundle between requesters, arbiter and mux
interface mux9_rr_arbiter_if;
  import mux9_arb_pkg::*;
  logic [N_REQ-1:0] req;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic [N_REQ-1:0] grant;
  logic             busy;
  modport master(input req, output sel, sel_valid, grant, busy);
  modport slave(output req, input sel, sel_valid, grant, busy);
endinterface

// File: rtl/mux9_rr_arbiter_pick.sv
// rr_pick9: rotate requests to start after last, priority-encode, rotate back to an input index
module rr_pick9
  import mux9_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] win
);
  logic [SEL_W-1:0] w_start;
  logic [N_REQ-1:0] w_rot;
  logic [SEL_W-1:0] w_off;
  assign w_start = mod9_add(last, 4'd1);
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < N_REQ; j++) w_rot[j] = req[mod9_add(w_start, 4'(j))];
    w_off = '0;
    for (int j = N_REQ - 1; j >= 0; j--) if (w_rot[j]) w_off = 4'(j);
  end
  assign any = |req;
  assign win = mod9_add(w_start, w_off);
endmodule

// File: rtl/mux9x1.sv
// mux9x1: 9:1 single-bit mux; out-of-range selects read as zero
module mux9x1 (
  input  logic [8:0] i,
  input  logic [3:0] sel,
  output logic       out
);
  assign out = (sel <= 4'd8) ? i[sel] : 1'b0;
endmodule

// File: rtl/mux9_rr_arbiter.sv
// mux9_rr_arbiter: round-robin owner of mux9x1 with burst limit and a turnaround cycle between grants
module mux9_rr_arbiter
  import mux9_arb_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 4
) (
  input logic clk,
  input logic rst_n,
  mux9_rr_arbiter_if.master bus
);
  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_grant;
  logic             r_sel_valid;
  logic             r_busy;
  logic             w_any;
  logic [SEL_W-1:0] w_win;
  logic             w_exit;
  rr_pick9 u_pick (.req(bus.req), .last(r_last), .any(w_any), .win(w_win));
  assign w_exit = !bus.req[r_sel] || (r_cnt == CNT_W'(BURST_LEN - 1));
  // sel is deliberately left alone on exit so the mux output stays stable through the turnaround
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_last      <= LAST_RST;
      r_cnt       <= '0;
      r_grant     <= '0;
      r_sel_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_any) begin
        r_state     <= GRANT;
        r_sel       <= w_win;
        r_last      <= w_win;
        r_cnt       <= '0;
        r_grant     <= N_REQ'(1) << w_win;
        r_sel_valid <= 1'b1;
        r_busy      <= 1'b1;
      end
    end else if (w_exit) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_grant     <= '0;
      r_sel_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
  assign bus.sel       = r_sel;
  assign bus.grant     = r_grant;
  assign bus.sel_valid = r_sel_valid;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_mux9_rr_arbiter.sv
// tb_mux9_rr_arbiter: directed checks of the arbiter with BURST_LEN=4 and BURST_LEN=1 builds
module tb_mux9_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [8:0] pat = 9'b101010101;
  logic mux_out;
  int checks = 0;
  int errors = 0;
  int run_a = 0;
  int run_b = 0;
  mux9_rr_arbiter_if a ();
  mux9_rr_arbiter_if b ();
  mux9_rr_arbiter #(.BURST_LEN(4), .CNT_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  mux9_rr_arbiter #(.BURST_LEN(1), .CNT_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
  mux9x1 u_mux (.i(pat), .sel(b.sel), .out(mux_out));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    a.req = '0;
    b.req = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_sel", 16'(a.sel), 16'd0);
    chk("rst_valid", 16'(a.sel_valid), 16'd0);
    chk("rst_grant", 16'(a.grant), 16'd0);
    chk("rst_busy", 16'(a.busy), 16'd0);
    rst_n = 1'b1;
  endtask
  task automatic burst(input int s, input int len);
    for (int k = 0; k < len; k++) begin
      tick;
      chk("burst_sel", 16'(a.sel), 16'(s));
      chk("burst_grant", 16'(a.grant), 16'(1) << s);
      chk("burst_valid", 16'(a.sel_valid), 16'd1);
    end
    tick;
    chk("gap_valid", 16'(a.sel_valid), 16'd0);
    chk("gap_grant", 16'(a.grant), 16'd0);
    chk("gap_sel", 16'(a.sel), 16'(s));
  endtask
  always @(negedge clk) begin
    run_a = a.sel_valid ? run_a + 1 : 0;
    run_b = b.sel_valid ? run_b + 1 : 0;
    checks++;
    assert (a.sel <= 4'd8 && $onehot0(a.grant) && ((a.grant != 9'd0) === a.sel_valid) &&
            (a.busy === a.sel_valid) && (!a.sel_valid || a.grant[a.sel]) && run_a <= 4) else begin
      errors++;
      $error("FAIL inv_a observed sel=%0h grant=%0h valid=%0b run=%0d expected legal", a.sel, a.grant, a.sel_valid, run_a);
    end
    checks++;
    assert (b.sel <= 4'd8 && $onehot0(b.grant) && ((b.grant != 9'd0) === b.sel_valid) &&
            (b.busy === b.sel_valid) && (!b.sel_valid || b.grant[b.sel]) && run_b <= 1) else begin
      errors++;
      $error("FAIL inv_b observed sel=%0h grant=%0h valid=%0b run=%0d expected legal", b.sel, b.grant, b.sel_valid, run_b);
    end
  end
  initial begin
    a.req = '0;
    b.req = '0;
    #1;
    // single requester: 4-cycle bursts separated by one idle cycle
    do_reset;
    a.req = 9'h001;
    #1;
    chk("no_comb_path", 16'(a.sel_valid), 16'd0);
    burst(0, 4);
    burst(0, 4);
    a.req = '0;
    tick;
    chk("stay_idle", 16'(a.sel_valid), 16'd0);
    // everyone requesting: strict rotation with wrap back to 0
    do_reset;
    a.req = 9'h1FF;
    for (int g = 0; g < 10; g++) burst(g % 9, 4);
    a.req = '0;
    tick;
    // owner drops early, then a new requester takes over
    do_reset;
    a.req = 9'h008;
    tick;
    chk("drop_sel", 16'(a.sel), 16'd3);
    chk("drop_grant1", 16'(a.grant), 16'h008);
    tick;
    chk("drop_grant2", 16'(a.grant), 16'h008);
    a.req = '0;
    tick;
    chk("drop_exit_valid", 16'(a.sel_valid), 16'd0);
    chk("drop_exit_grant", 16'(a.grant), 16'd0);
    chk("drop_exit_sel", 16'(a.sel), 16'd3);
    a.req = 9'h020;
    tick;
    chk("next_sel", 16'(a.sel), 16'd5);
    chk("next_grant", 16'(a.grant), 16'h020);
    a.req = '0;
    tick;
    chk("next_exit", 16'(a.sel_valid), 16'd0);
    // wrap-around fairness between inputs 0 and 8
    do_reset;
    a.req = 9'h101;
    burst(0, 4);
    burst(8, 4);
    burst(0, 4);
    a.req = '0;
    tick;
    // asynchronous reset in the middle of a grant to input 6
    do_reset;
    a.req = 9'h040;
    tick;
    tick;
    chk("pre_rst_sel", 16'(a.sel), 16'd6);
    chk("pre_rst_valid", 16'(a.sel_valid), 16'd1);
    #2;
    do_reset;
    a.req = 9'h044;
    tick;
    chk("post_rst_sel", 16'(a.sel), 16'd2);
    chk("post_rst_grant", 16'(a.grant), 16'h004);
    a.req = '0;
    tick;
    tick;
    // BURST_LEN=1 build driving the mux
    do_reset;
    b.req = 9'h1FF;
    for (int g = 0; g < 10; g++) begin
      tick;
      chk("b1_sel", 16'(b.sel), 16'(g % 9));
      chk("b1_grant", 16'(b.grant), 16'(1) << (g % 9));
      chk("b1_valid", 16'(b.sel_valid), 16'd1);
      chk("b1_out", 16'(mux_out), ((g % 9) % 2 == 0) ? 16'd1 : 16'd0);
      tick;
      chk("b1_gap_valid", 16'(b.sel_valid), 16'd0);
      chk("b1_gap_sel", 16'(b.sel), 16'(g % 9));
    end
    b.req = '0;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
